decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, datapath width, 32 or 64; HAZARD_EN, 1, enables the load-use interlock; BUBBLES, 1, load-use bubble cycles, 1..3.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid/in_ready  in/out  1/1  fetch-side handshake.
REQ-006 in_instr  in  32  instruction word.
REQ-007 in_pc  in  XLEN  PC of in_instr.
REQ-008 flush  in  1  kills held and incoming instruction.
REQ-009 out_valid/out_ready  out/in  1/1  execute-side handshake.
REQ-010 out_pc  out  XLEN  registered copy of in_pc.
REQ-011 out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7].
REQ-012 out_imm  out  XLEN  immediate, sign-extended to XLEN.
REQ-013 out_alu_op  out  3  ALUOP_* code.
REQ-014 out_op1_src, out_op2_src  out  1 each  0 = rs1/rs2; 1 = PC/imm.
REQ-015 out_wb_src  out  2  writeback source: 0 = ALU, 1 = MEM, 2 = PC+4.
REQ-016 out_reg_we, out_mem_re, out_mem_we, out_illegal  out  1 each  control flags.

Function
REQ-017 Decode table per opcode (op1src/op2src/wb/alu/we/re/me):
- R: 0/0/0/RTYPE/1/0/0; I-arith: 0/1/0/ITYPE/1/0/0
- LOAD: 0/1/1/ADD/1/1/0; STORE: 0/1/0/ADD/0/0/1; BRANCH: 0/0/0/BRANCH/0/0/0
- LUI: 0/1/0/LUI/1/0/0; AUIPC: 1/1/0/ADD/1/0/0
- JAL: 1/1/2/JUMP/1/0/0; JALR: 0/1/2/JUMP/1/0/0
REQ-018 Illegal conditions: instr[1:0]!=2'b11; unknown opcode; LOAD funct3 in {3,6,7}; STORE funct3>2; BRANCH funct3 in {2,3}; JALR funct3!=0; R-type funct7 not in {0x00,0x20}, or 0x20 with funct3 not in {0,5}; I-type SLLI with funct7!=0; I-type SRLI/SRAI with funct7 not in {0x00,0x20}.
REQ-019 Illegal instruction: out_illegal=1; we/re/me forced 0; alu_op ADD; still delivered with out_valid=1.
REQ-020 Source use for interlock: rs1 used by R/I/LOAD/STORE/BRANCH/JALR; rs2 by R/STORE/BRANCH.
REQ-021 One-entry output register; decode-to-out latency is exactly 1 cycle.
REQ-022 States: EMPTY, FULL, STALL.
REQ-023 luh = HAZARD_EN & FULL & out_mem_re & out_rd!=0 & in_valid & an incoming used rs equals out_rd.
REQ-024 in_ready = !flush & (EMPTY | (FULL & out_ready & !luh)); 0 in STALL.
REQ-025 Transitions:
- EMPTY & in_valid -> FULL
- FULL & out_ready & in_valid & !luh -> FULL, loading the new instruction
- FULL & out_ready & !in_valid -> EMPTY
- FULL & out_ready & luh -> STALL, with bubble counter = BUBBLES-1
- STALL & counter==0 -> EMPTY; otherwise decrement the counter
- FULL & !out_ready -> hold
REQ-026 Output fields are stable while out_valid & !out_ready.
REQ-027 out_valid=1 only in FULL.
REQ-028 flush has top priority: next state EMPTY, counter cleared, and the instruction presented in the flush cycle is not accepted.

Reset
REQ-029 While rst=1: state EMPTY; out_valid=0; in_ready=0; counter=0.
REQ-030 While rst=1, all out_* data/control fields are 0 and out_illegal=0.
REQ-031 rst asserted mid-stall or mid-transfer discards the held instruction; in_ready=1 the first cycle after release.

Structure
REQ-032 The following live in the shared rv32i definitions package: OPC_*, ALUOP_*, and WB_ALU/WB_MEM/WB_PC4.
REQ-033 One combinational sub-module, rv_ctrl_decode (instr -> controls, imm, illegal, rs-use), instantiated once; the state machine and registers are in decode_stage.

Verification
REQ-034 Reset: rst=1 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=0 throughout; in_ready=1 the cycle after release.
REQ-035 Single instruction: 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, op2_src=1, reg_we=1, alu_op=ITYPE, pc=0x100.
REQ-036 Load-use stall: 0x0000A283 (lw x5) then 0x00228333 (add x6,x5,x2), out_ready=1, BUBBLES=2 -> lw out; in_ready=0 and 2 cycles out_valid=0; add appears on the 4th cycle after lw.
REQ-037 No stall on x0 or with HAZARD_EN=0: lw x0 followed by add x6,x0,x2, and the REQ-036 pair with HAZARD_EN=0 -> back-to-back delivery with no bubble.
REQ-038 Back-pressure and flush: out_ready=0 for 3 cycles -> fields stable, in_ready=0. Flush in FULL or STALL -> out_valid=0 the next cycle, then normal accept.
REQ-039 Illegal: 0xFFFFFFFF and 0x0000F003 (LOAD funct3=7) -> out_illegal=1, reg_we=mem_re=mem_we=0, out_valid=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared rv32i decode definitions: opcodes, ALU op codes, writeback sources and
// the decode-stage state encoding.
package decode_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned WB_W    = 2;
    localparam int unsigned CNT_W   = 2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 3'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 3'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_ITYPE  = 3'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 3'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_JUMP   = 3'd5;

    localparam logic [WB_W-1:0] WB_ALU = 2'd0;
    localparam logic [WB_W-1:0] WB_MEM = 2'd1;
    localparam logic [WB_W-1:0] WB_PC4 = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/decode_stage_ctrl.sv
// Combinational RV32I control decode: instruction word to control flags,
// sign-extended immediate, illegal flag and source-register usage.
module rv_ctrl_decode
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      alu_op,
    output logic            op1_src,
    output logic            op2_src,
    output logic [1:0]      wb_src,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            illegal,
    output logic            rs1_used,
    output logic            rs2_used
);

    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;
    logic               bad;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = 32'($signed(instr[31:20]));
    assign imm_s = 32'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = $signed({instr[31:12], 12'b0});
    assign imm_j = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    always_comb begin
        imm      = '0;
        alu_op   = ALUOP_ADD;
        op1_src  = 1'b0;
        op2_src  = 1'b0;
        wb_src   = WB_ALU;
        reg_we   = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        bad      = 1'b0;

        case (opcode)
            OPC_OP: begin
                alu_op   = ALUOP_RTYPE;
                reg_we   = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                bad      = !((f7 == 7'h00) ||
                             ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_OP_IMM: begin
                imm      = XLEN'(imm_i);
                alu_op   = ALUOP_ITYPE;
                op2_src  = 1'b1;
                reg_we   = 1'b1;
                rs1_used = 1'b1;
                if (f3 == 3'd1)
                    bad = (f7 != 7'h00);
                else if (f3 == 3'd5)
                    bad = (f7 != 7'h00) && (f7 != 7'h20);
            end
            OPC_LOAD: begin
                imm      = XLEN'(imm_i);
                op2_src  = 1'b1;
                wb_src   = WB_MEM;
                reg_we   = 1'b1;
                mem_re   = 1'b1;
                rs1_used = 1'b1;
                bad      = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                imm      = XLEN'(imm_s);
                op2_src  = 1'b1;
                mem_we   = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                bad      = (f3 > 3'd2);
            end
            OPC_BRANCH: begin
                imm      = XLEN'(imm_b);
                alu_op   = ALUOP_BRANCH;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                bad      = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LUI: begin
                imm     = XLEN'(imm_u);
                alu_op  = ALUOP_LUI;
                op2_src = 1'b1;
                reg_we  = 1'b1;
            end
            OPC_AUIPC: begin
                imm     = XLEN'(imm_u);
                op1_src = 1'b1;
                op2_src = 1'b1;
                reg_we  = 1'b1;
            end
            OPC_JAL: begin
                imm     = XLEN'(imm_j);
                alu_op  = ALUOP_JUMP;
                op1_src = 1'b1;
                op2_src = 1'b1;
                wb_src  = WB_PC4;
                reg_we  = 1'b1;
            end
            OPC_JALR: begin
                imm      = XLEN'(imm_i);
                alu_op   = ALUOP_JUMP;
                op2_src  = 1'b1;
                wb_src   = WB_PC4;
                reg_we   = 1'b1;
                rs1_used = 1'b1;
                bad      = (f3 != 3'd0);
            end
            default: bad = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            bad = 1'b1;

        // Illegal instructions still flow down the pipe, but with no side effects.
        if (bad) begin
            reg_we = 1'b0;
            mem_re = 1'b0;
            mem_we = 1'b0;
            alu_op = ALUOP_ADD;
        end
        illegal = bad;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry registered output slot with valid/ready handshakes,
// load-use interlock with programmable bubble count, and flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned HAZARD_EN = 1,
    parameter int unsigned BUBBLES   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_alu_op,
    output logic            out_op1_src,
    output logic            out_op2_src,
    output logic [1:0]      out_wb_src,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic            out_illegal
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             luh;

    logic [XLEN-1:0]    dec_imm;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_op1_src;
    logic               dec_op2_src;
    logic [WB_W-1:0]    dec_wb_src;
    logic               dec_reg_we;
    logic               dec_mem_re;
    logic               dec_mem_we;
    logic               dec_illegal;
    logic               dec_rs1_used;
    logic               dec_rs2_used;

    rv_ctrl_decode #(.XLEN(XLEN)) u_ctrl (
        .instr    (in_instr),
        .imm      (dec_imm),
        .alu_op   (dec_alu_op),
        .op1_src  (dec_op1_src),
        .op2_src  (dec_op2_src),
        .wb_src   (dec_wb_src),
        .reg_we   (dec_reg_we),
        .mem_re   (dec_mem_re),
        .mem_we   (dec_mem_we),
        .illegal  (dec_illegal),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // Load-use hazard: the held load writes a register the incoming instruction reads.
    always_comb begin
        luh = (HAZARD_EN != 0) && (state == ST_FULL) && out_mem_re &&
              (out_rd != 5'd0) && in_valid &&
              ((dec_rs1_used && (in_instr[19:15] == out_rd)) ||
               (dec_rs2_used && (in_instr[24:20] == out_rd)));
        in_ready = !rst && !flush &&
                   ((state == ST_EMPTY) || ((state == ST_FULL) && out_ready && !luh));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_alu_op  <= '0;
            out_op1_src <= 1'b0;
            out_op2_src <= 1'b0;
            out_wb_src  <= '0;
            out_reg_we  <= 1'b0;
            out_mem_re  <= 1'b0;
            out_mem_we  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                out_pc      <= in_pc;
                out_rs1     <= in_instr[19:15];
                out_rs2     <= in_instr[24:20];
                out_rd      <= in_instr[11:7];
                out_imm     <= dec_imm;
                out_alu_op  <= dec_alu_op;
                out_op1_src <= dec_op1_src;
                out_op2_src <= dec_op2_src;
                out_wb_src  <= dec_wb_src;
                out_reg_we  <= dec_reg_we;
                out_mem_re  <= dec_mem_re;
                out_mem_we  <= dec_mem_we;
                out_illegal <= dec_illegal;
            end

            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (luh) begin
                            state     <= ST_STALL;
                            cnt       <= CNT_W'(BUBBLES - 1);
                            out_valid <= 1'b0;
                        end else if (!in_valid) begin
                            state     <= ST_EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    if (cnt == '0)
                        state <= ST_EMPTY;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected decodes, a
// negedge monitor pops and compares on every output handshake.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  alu;
        logic        op1;
        logic        op2;
        logic [1:0]  wb;
        logic        we;
        logic        re;
        logic        me;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_alu_op;
    logic        out_op1_src, out_op2_src;
    logic [1:0]  out_wb_src;
    logic        out_reg_we, out_mem_re, out_mem_we, out_illegal;

    logic        nh_in_ready, nh_out_valid;
    logic [31:0] nh_out_pc, nh_out_imm;
    logic [4:0]  nh_out_rs1, nh_out_rs2, nh_out_rd;
    logic [2:0]  nh_out_alu_op;
    logic        nh_out_op1_src, nh_out_op2_src;
    logic [1:0]  nh_out_wb_src;
    logic        nh_out_reg_we, nh_out_mem_re, nh_out_mem_we, nh_out_illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t dummy;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .HAZARD_EN(1), .BUBBLES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_op1_src(out_op1_src), .out_op2_src(out_op2_src),
        .out_wb_src(out_wb_src), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
        .out_mem_we(out_mem_we), .out_illegal(out_illegal)
    );

    // Same stimulus, interlock disabled: used only to show back-to-back delivery.
    decode_stage #(.XLEN(32), .HAZARD_EN(0), .BUBBLES(2)) u_nohz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nh_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(nh_out_valid), .out_ready(out_ready), .out_pc(nh_out_pc),
        .out_rs1(nh_out_rs1), .out_rs2(nh_out_rs2), .out_rd(nh_out_rd), .out_imm(nh_out_imm),
        .out_alu_op(nh_out_alu_op), .out_op1_src(nh_out_op1_src), .out_op2_src(nh_out_op2_src),
        .out_wb_src(nh_out_wb_src), .out_reg_we(nh_out_reg_we), .out_mem_re(nh_out_mem_re),
        .out_mem_we(nh_out_mem_we), .out_illegal(nh_out_illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [2:0] alu,
                                input logic op1, input logic op2, input logic [1:0] wb,
                                input logic we, input logic re, input logic me,
                                input logic ill);
        exp_t e;
        e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.alu = alu;
        e.op1 = op1; e.op2 = op2; e.wb = wb; e.we = we; e.re = re; e.me = me; e.ill = ill;
        return e;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; expected decode is queued when it is accepted.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                        input int budget, input string name);
        int k = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(in_ready), 64'd1);
        if (in_ready)
            exp_q.push_back(e);
        sync();
        in_valid = 1'b0;
    endtask

    // Monitor: every handshake on the output side consumes one expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got pc 0x%0h, expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc",      64'(out_pc),      64'(mon_e.pc));
                check("out_rs1",     64'(out_rs1),     64'(mon_e.rs1));
                check("out_rs2",     64'(out_rs2),     64'(mon_e.rs2));
                check("out_rd",      64'(out_rd),      64'(mon_e.rd));
                check("out_imm",     64'(out_imm),     64'(mon_e.imm));
                check("out_alu_op",  64'(out_alu_op),  64'(mon_e.alu));
                check("out_op1_src", 64'(out_op1_src), 64'(mon_e.op1));
                check("out_op2_src", 64'(out_op2_src), 64'(mon_e.op2));
                check("out_wb_src",  64'(out_wb_src),  64'(mon_e.wb));
                check("out_reg_we",  64'(out_reg_we),  64'(mon_e.we));
                check("out_mem_re",  64'(out_mem_re),  64'(mon_e.re));
                check("out_mem_we",  64'(out_mem_we),  64'(mon_e.me));
                check("out_illegal", 64'(out_illegal), 64'(mon_e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        in_pc     = 32'h100;

        // Reset held three cycles with a valid instruction waiting
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready",  64'(in_ready),  64'd0);
            check("rst_fields",    {out_rd, out_imm, out_reg_we, out_illegal}, 64'd0);
        end
        sync();
        rst = 1'b0;

        // addi x1,x0,5
        send(32'h00500093, 32'h100,
             mk(32'h100, 5'd0, 5'd5, 5'd1, 32'd5, ALUOP_ITYPE, 1'b0, 1'b1, WB_ALU,
                1'b1, 1'b0, 1'b0, 1'b0), 0, "ready_after_reset");
        @(negedge clk);
        check("single_latency", 64'(out_valid), 64'd1);
        sync();

        // lw x5,0(x1) then add x6,x5,x2: two bubbles then the add
        send(32'h0000A283, 32'h104,
             mk(32'h104, 5'd1, 5'd0, 5'd5, 32'd0, ALUOP_ADD, 1'b0, 1'b1, WB_MEM,
                1'b1, 1'b1, 1'b0, 1'b0), 0, "lw_accept");
        in_valid = 1'b1;
        in_instr = 32'h00228333;
        in_pc    = 32'h108;
        @(negedge clk);
        check("luh_lw_visible", 64'(out_valid),   64'd1);
        check("luh_in_ready",   64'(in_ready),    64'd0);
        check("nohz_in_ready",  64'(nh_in_ready), 64'd1);
        @(negedge clk);
        check("nohz_back2back", {nh_out_valid, 3'b000, nh_out_rd}, {1'b1, 3'b000, 5'd6});
        check("stall_bubble1",  {out_valid, in_ready}, 64'd0);
        @(negedge clk);
        check("stall_bubble2",  {out_valid, in_ready}, 64'd0);
        @(negedge clk);
        check("stall_out_idle", 64'(out_valid), 64'd0);
        check("stall_release",  64'(in_ready),  64'd1);
        if (in_ready)
            exp_q.push_back(mk(32'h108, 5'd5, 5'd2, 5'd6, 32'd0, ALUOP_RTYPE, 1'b0, 1'b0,
                               WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0));
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_add_4th_cycle", 64'(out_valid), 64'd1);
        sync();

        // lw x0 followed by add x6,x0,x2: no interlock
        send(32'h0000A003, 32'h10C,
             mk(32'h10C, 5'd1, 5'd0, 5'd0, 32'd0, ALUOP_ADD, 1'b0, 1'b1, WB_MEM,
                1'b1, 1'b1, 1'b0, 1'b0), 0, "lw_x0_accept");
        send(32'h00200333, 32'h110,
             mk(32'h110, 5'd0, 5'd2, 5'd6, 32'd0, ALUOP_RTYPE, 1'b0, 1'b0, WB_ALU,
                1'b1, 1'b0, 1'b0, 1'b0), 0, "x0_no_stall");

        // lui x3,0x12345 held under back-pressure, jal x1,-4 waiting
        send(32'h123451B7, 32'h114,
             mk(32'h114, 5'd8, 5'd3, 5'd3, 32'h12345000, ALUOP_LUI, 1'b0, 1'b1, WB_ALU,
                1'b1, 1'b0, 1'b0, 1'b0), 0, "lui_accept");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFDFF0EF;
        in_pc     = 32'h118;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid_held", 64'(out_valid), 64'd1);
            check("bp_in_ready",   64'(in_ready),  64'd0);
            check("bp_stable", {out_pc, out_imm}, {32'h114, 32'h12345000});
        end
        sync();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        if (in_ready)
            exp_q.push_back(mk(32'h118, 5'd31, 5'd29, 5'd1, 32'hFFFFFFFC, ALUOP_JUMP,
                               1'b1, 1'b1, WB_PC4, 1'b1, 1'b0, 1'b0, 1'b0));
        sync();
        in_valid = 1'b0;

        // sw x2,8(x1), then two illegal words
        send(32'h0020A423, 32'h11C,
             mk(32'h11C, 5'd1, 5'd2, 5'd8, 32'd8, ALUOP_ADD, 1'b0, 1'b1, WB_ALU,
                1'b0, 1'b0, 1'b1, 1'b0), 0, "sw_accept");
        send(32'hFFFFFFFF, 32'h120,
             mk(32'h120, 5'd31, 5'd31, 5'd31, 32'd0, ALUOP_ADD, 1'b0, 1'b0, WB_ALU,
                1'b0, 1'b0, 1'b0, 1'b1), 0, "ill_ones_accept");
        send(32'h0000F003, 32'h124,
             mk(32'h124, 5'd1, 5'd0, 5'd0, 32'd0, ALUOP_ADD, 1'b0, 1'b1, WB_MEM,
                1'b0, 1'b0, 1'b0, 1'b1), 0, "ill_load_accept");
        repeat (2) sync();

        // Flush while FULL and stalled downstream
        out_ready = 1'b0;
        send(32'h00500093, 32'h200, mk(32'h200, 5'd0, 5'd5, 5'd1, 32'd5, ALUOP_ITYPE,
             1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0), 0, "pre_flush_accept");
        dummy    = exp_q.pop_back();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h123451B7;
        in_pc    = 32'h1FC;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        sync();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_full_drop", 64'(out_valid), 64'd0);
        sync();
        send(32'h00500093, 32'h204, mk(32'h204, 5'd0, 5'd5, 5'd1, 32'd5, ALUOP_ITYPE,
             1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0), 0, "flush_full_accept");

        // Flush in STALL: the waiting add is accepted right away
        send(32'h0000A283, 32'h300, mk(32'h300, 5'd1, 5'd0, 5'd5, 32'd0, ALUOP_ADD,
             1'b0, 1'b1, WB_MEM, 1'b1, 1'b1, 1'b0, 1'b0), 0, "lw2_accept");
        in_valid = 1'b1;
        in_instr = 32'h00228333;
        in_pc    = 32'h304;
        @(negedge clk);
        sync();
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {out_valid, in_ready}, 64'd0);
        sync();
        flush = 1'b0;
        @(negedge clk);
        check("flush_stall_accept", 64'(in_ready), 64'd1);
        if (in_ready)
            exp_q.push_back(mk(32'h304, 5'd5, 5'd2, 5'd6, 32'd0, ALUOP_RTYPE, 1'b0, 1'b0,
                               WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0));
        sync();
        in_valid = 1'b0;
        repeat (2) sync();

        // Reset during a held transfer discards it
        out_ready = 1'b0;
        send(32'h00500093, 32'h400, mk(32'h400, 5'd0, 5'd5, 5'd1, 32'd5, ALUOP_ITYPE,
             1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0), 0, "pre_rst_accept");
        dummy = exp_q.pop_back();
        rst   = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        sync();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_drop",     64'(out_valid), 64'd0);
        check("rst_mid_ready",    64'(in_ready),  64'd1);
        sync();
        send(32'h00500093, 32'h404, mk(32'h404, 5'd0, 5'd5, 5'd1, 32'd5, ALUOP_ITYPE,
             1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0), 0, "post_rst_accept");

        repeat (3) sync();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
